// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - VGA raster timing: syncs, visible flag, coordinates, strobes
// Optional frame counter enabled by defining VGA_TIMING_FRAME_COUNTER_EN.
module vga_timing_generator #(
  parameter int H_VISIBLE      = 640,
  parameter int H_FRONT        = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BACK         = 48,
  parameter int V_VISIBLE      = 480,
  parameter int V_FRONT        = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BACK         = 33,
  parameter int HSYNC_POSITIVE = 0,
  parameter int VSYNC_POSITIVE = 0,
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int XW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1,
  localparam int YW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          pixel_en,
  output logic          vga_hsync,
  output logic          vga_vsync,
  output logic          vga_visible,
  output logic [XW-1:0] pixel_x,
  output logic [YW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [15:0]   frame_count
);

  typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;

  localparam logic HS_ON = (HSYNC_POSITIVE != 0);
  localparam logic VS_ON = (VSYNC_POSITIVE != 0);

  phase_t          h_phase, h_phase_n, v_phase, v_phase_n;
  logic [XW-1:0]   h_cnt, h_cnt_n, h_last, x_n;
  logic [YW-1:0]   v_cnt, v_cnt_n, v_last, y_n;
  logic            h_end, v_end, h_wrap, v_wrap;

  function automatic phase_t phase_after(input phase_t p);
    case (p)
      PH_ACTIVE: phase_after = PH_FRONT;
      PH_FRONT:  phase_after = PH_SYNC;
      PH_SYNC:   phase_after = PH_BACK;
      default:   phase_after = PH_ACTIVE;
    endcase
  endfunction

  always_comb begin
    h_last = XW'(H_BACK - 1);
    case (h_phase)
      PH_ACTIVE: h_last = XW'(H_VISIBLE - 1);
      PH_FRONT:  h_last = XW'(H_FRONT - 1);
      PH_SYNC:   h_last = XW'(H_SYNC - 1);
      default:   h_last = XW'(H_BACK - 1);
    endcase
    v_last = YW'(V_BACK - 1);
    case (v_phase)
      PH_ACTIVE: v_last = YW'(V_VISIBLE - 1);
      PH_FRONT:  v_last = YW'(V_FRONT - 1);
      PH_SYNC:   v_last = YW'(V_SYNC - 1);
      default:   v_last = YW'(V_BACK - 1);
    endcase
  end

  assign h_end  = (h_cnt == h_last);
  assign v_end  = (v_cnt == v_last);
  assign h_wrap = h_end && (h_phase == PH_BACK);
  assign v_wrap = v_end && (v_phase == PH_BACK);

  // Vertical phase only moves on the pixel that wraps the line back to x = 0.
  always_comb begin
    h_phase_n = h_phase;
    h_cnt_n   = h_cnt;
    x_n       = pixel_x;
    v_phase_n = v_phase;
    v_cnt_n   = v_cnt;
    y_n       = pixel_y;
    if (pixel_en) begin
      if (h_end) begin
        h_phase_n = phase_after(h_phase);
        h_cnt_n   = '0;
      end else begin
        h_cnt_n = h_cnt + 1'b1;
      end
      x_n = h_wrap ? '0 : pixel_x + 1'b1;
      if (h_wrap) begin
        if (v_end) begin
          v_phase_n = phase_after(v_phase);
          v_cnt_n   = '0;
        end else begin
          v_cnt_n = v_cnt + 1'b1;
        end
        y_n = v_wrap ? '0 : pixel_y + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      h_phase     <= PH_BACK;
      h_cnt       <= XW'(H_BACK - 1);
      pixel_x     <= XW'(H_TOTAL - 1);
      v_phase     <= PH_BACK;
      v_cnt       <= YW'(V_BACK - 1);
      pixel_y     <= YW'(V_TOTAL - 1);
      vga_hsync   <= ~HS_ON;
      vga_vsync   <= ~VS_ON;
      vga_visible <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_phase     <= h_phase_n;
      h_cnt       <= h_cnt_n;
      pixel_x     <= x_n;
      v_phase     <= v_phase_n;
      v_cnt       <= v_cnt_n;
      pixel_y     <= y_n;
      line_start  <= pixel_en && h_wrap;
      frame_start <= pixel_en && h_wrap && v_wrap;
      if (pixel_en) begin
        vga_hsync   <= (h_phase_n == PH_SYNC) ? HS_ON : ~HS_ON;
        vga_vsync   <= (v_phase_n == PH_SYNC) ? VS_ON : ~VS_ON;
        vga_visible <= (h_phase_n == PH_ACTIVE) && (v_phase_n == PH_ACTIVE);
      end
    end
  end

`ifdef VGA_TIMING_FRAME_COUNTER_EN
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (pixel_en && h_wrap && v_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - bench for vga_timing_generator, both sync polarities
// Frame counter checks follow VGA_TIMING_FRAME_COUNTER_EN.
module tb_vga_timing_generator;

  logic        vga_clk = 1'b0;
  logic        reset   = 1'b1;
  logic        pixel_en = 1'b0;
  logic        hs_p, vs_p, vis_p, ls_p, fs_p;
  logic        hs_n, vs_n, vis_n, ls_n, fs_n;
  logic [2:0]  x_p, y_p, x_n, y_n;
  logic [15:0] fc_p, fc_n;

  int vectors = 0;
  int errors  = 0;

  int m_x, m_y, m_fc;
  logic m_ls, m_fs;

  always #5 vga_clk = ~vga_clk;

  vga_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POSITIVE(1), .VSYNC_POSITIVE(1)
  ) dut_pos (
    .vga_clk(vga_clk), .reset(reset), .pixel_en(pixel_en),
    .vga_hsync(hs_p), .vga_vsync(vs_p), .vga_visible(vis_p),
    .pixel_x(x_p), .pixel_y(y_p), .line_start(ls_p), .frame_start(fs_p),
    .frame_count(fc_p)
  );

  vga_timing_generator #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POSITIVE(0), .VSYNC_POSITIVE(0)
  ) dut_neg (
    .vga_clk(vga_clk), .reset(reset), .pixel_en(pixel_en),
    .vga_hsync(hs_n), .vga_vsync(vs_n), .vga_visible(vis_n),
    .pixel_x(x_n), .pixel_y(y_n), .line_start(ls_n), .frame_start(fs_n),
    .frame_count(fc_n)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at x=%0d y=%0d t=%0t", tag, obs, exp, m_x, m_y, $time);
    end
  endtask

  function automatic logic [15:0] exp_fc();
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    return 16'(m_fc);
`else
    return 16'd0;
`endif
  endfunction

  // Model state is just the raster position; everything else is derived from it.
  task automatic model_reset();
    m_x = 7; m_y = 5; m_ls = 1'b0; m_fs = 1'b0; m_fc = 0;
  endtask

  task automatic check_all(input logic in_reset);
    logic vis, hs, vs;
    vis = !in_reset && (m_x < 4) && (m_y < 3);
    hs  = !in_reset && (m_x >= 5) && (m_x <= 6);
    vs  = !in_reset && (m_y == 4);
    chk("pixel_x",     16'(x_p), 16'(m_x));
    chk("pixel_y",     16'(y_p), 16'(m_y));
    chk("visible",     16'(vis_p), 16'(vis));
    chk("hsync_pos",   16'(hs_p), 16'(hs));
    chk("vsync_pos",   16'(vs_p), 16'(vs));
    chk("line_start",  16'(ls_p), 16'(m_ls));
    chk("frame_start", 16'(fs_p), 16'(m_fs));
    chk("frame_count", fc_p, exp_fc());
    chk("pixel_x_neg", 16'(x_n), 16'(m_x));
    chk("visible_neg", 16'(vis_n), 16'(vis));
    chk("hsync_neg",   16'(hs_n), 16'(!hs));
    chk("vsync_neg",   16'(vs_n), 16'(!vs));
    chk("fs_neg",      16'(fs_n), 16'(m_fs));
  endtask

  task automatic step(input logic en);
    pixel_en = en;
    @(posedge vga_clk);
    if (en) begin
      m_x = (m_x + 1) % 8;
      if (m_x == 0) m_y = (m_y + 1) % 6;
      m_ls = (m_x == 0);
      m_fs = m_ls && (m_y == 0);
      if (m_fs) m_fc++;
    end else begin
      m_ls = 1'b0;
      m_fs = 1'b0;
    end
    #1;
    check_all(1'b0);
  endtask

  initial begin
    int last_fs, en_cycles, starts, guard;
    model_reset();
    repeat (3) @(posedge vga_clk);
    #1;
    check_all(1'b1);
    #2 reset = 1'b0;

    // Continuous enable: two frames, frame_start spacing measured independently.
    last_fs = -1; en_cycles = 0;
    for (int i = 0; i < 96; i++) begin
      step(1'b1);
      en_cycles++;
      if (fs_p) begin
        if (last_fs >= 0) chk("fs_period", 16'(en_cycles - last_fs), 16'd48);
        last_fs = en_cycles;
      end
    end

    // Explicit 1,0,0,1 pattern, then random duty.
    step(1'b1); step(1'b0); step(1'b0); step(1'b1);
    last_fs = -1; en_cycles = 0;
    for (int i = 0; i < 300; i++) begin
      logic en;
      en = 1'($urandom);
      step(en);
      if (en) begin
        en_cycles++;
        if (fs_p) begin
          if (last_fs >= 0) chk("fs_period_rand", 16'(en_cycles - last_fs), 16'd48);
          last_fs = en_cycles;
        end
      end
    end

    // Asynchronous reset at (2,1), checked before any clock edge.
    guard = 0;
    while (!(m_x == 2 && m_y == 1) && guard < 100) begin
      step(1'b1);
      guard++;
    end
    chk("reach_2_1", 16'(guard < 100), 16'd1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_all(1'b1);
    #2 reset = 1'b0;
    step(1'b1);
    chk("restart_fs", 16'(fs_p), 16'd1);

    // Three frame starts since reset.
    starts = 1; guard = 0;
    while (starts < 3 && guard < 200) begin
      step(1'b1);
      if (fs_p) starts++;
      guard++;
    end
    chk("third_fs_seen", 16'(starts), 16'd3);
`ifdef VGA_TIMING_FRAME_COUNTER_EN
    chk("fc_after_3", fc_p, 16'd3);
`else
    chk("fc_after_3", fc_p, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
